// File: rtl/fifo_nibble_tx.sv
// Purpose: pops words from the nibble FIFO and sends each as a UART-style frame (start, data LSB first, [parity], stop).
// Latency: tx_out falls the cycle after fifo_pop; back-to-back frames every (2+DATA_W[+1])*CLKS_PER_BIT cycles.
// Backpressure: pops only when tx_en=1 and fifo_empty=0; at most one pop per frame. Parity is enabled by FIFO_TX_PARITY_EN.
module fifo_nibble_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  word_count
);

    localparam int               IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]       LAST_TICK = 8'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

`ifdef FIFO_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        bit_timer;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              last_tick;
    logic              launch;
`ifdef FIFO_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign last_tick = (bit_timer == LAST_TICK);
    // A frame may begin only when permitted, data is present and we are not being reset.
    assign launch    = tx_en & ~fifo_empty & ~reset;

    // Next-state and Mealy outputs; a launch in the last STOP cycle chains straight into START.
    always_comb begin
        state_nxt  = state;
        fifo_pop   = 1'b0;
        tx_out     = 1'b1;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (launch) begin
                    fifo_pop  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_out = 1'b0;
                if (last_tick) state_nxt = DATA;
            end
            DATA: begin
                tx_out = shift_reg[0];
                if (last_tick && (bit_idx == LAST_IDX)) begin
`ifdef FIFO_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: begin
                tx_out = parity_bit;
                if (last_tick) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (last_tick) begin
                    frame_done = ~reset;
                    if (launch) begin
                        fifo_pop  = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Bit timer: counts cycles within each serial bit, parked at zero while idle.
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE) || last_tick) bit_timer <= 8'd0;
        else                                      bit_timer <= bit_timer + 8'd1;
    end

    // Shift register and bit index: load on pop, advance at the end of each data bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_idx   <= '0;
        end else if (fifo_pop) begin
            shift_reg <= fifo_data;
            bit_idx   <= '0;
        end else if ((state == DATA) && last_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 1'b1;
        end
    end

`ifdef FIFO_TX_PARITY_EN
    // Even parity is taken from the word as loaded, since the shift register is consumed during DATA.
    always_ff @(posedge clk) begin
        if (reset)         parity_bit <= 1'b0;
        else if (fifo_pop) parity_bit <= ^fifo_data;
    end
`endif

    // Completed-frame counter, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset)           word_count <= '0;
        else if (frame_done) word_count <= word_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// Bench for fifo_nibble_tx: a queue models the FIFO, pops push expected frames to a scoreboard,
// and each frame_done compares the captured serial line against the frame built from the popped word.
module tb_fifo_nibble_tx;

    localparam int DATA_W = 4;
    localparam int CPB    = 4;
    localparam int CNT_W  = 8;
`ifdef FIFO_TX_PARITY_EN
    localparam int NBITS  = DATA_W + 3;
`else
    localparam int NBITS  = DATA_W + 2;
`endif
    localparam int F      = NBITS * CPB;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tx_en = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_pop;
    logic              tx_out;
    logic              busy;
    logic              frame_done;
    logic [CNT_W-1:0]  word_count;

    fifo_nibble_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] word;
        int                pop_cyc;
    } sb_t;

    typedef struct {
        logic [DATA_W-1:0] word;
        logic              exp_par;
        int                exp_cnt;
    } vec_t;

    int                errors = 0;
    int                checks = 0;
    int                cycle  = 0;
    int                pop_count = 0;
    int                pop_log[$];
    logic [DATA_W-1:0] fifo_q[$];
    sb_t               sb_q[$];
    logic              line_cap[$];
    logic              last_line[$];
    vec_t              vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // One clock: monitor at the falling edge, then advance the FIFO model after the rising edge.
    task automatic cyc();
        logic popped;
        @(negedge clk);
        popped = (fifo_pop === 1'b1);
        if (busy === 1'b1) line_cap.push_back(tx_out);
        if (reset === 1'b0 && busy === 1'b0) check("idle_line", tx_out, 1);
        if (frame_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("frame_without_pop", 1, 0);
            end else begin
                sb_t e;
                int  bad;
                e   = sb_q.pop_front();
                bad = 0;
                check("frame_len", line_cap.size(), F);
                check("done_latency", cycle - e.pop_cyc, F);
                for (int c = 0; c < F; c++) begin
                    int   b;
                    logic x;
                    b = c / CPB;
                    if (b == 0)            x = 1'b0;
                    else if (b <= DATA_W)  x = e.word[b-1];
`ifdef FIFO_TX_PARITY_EN
                    else if (b == DATA_W+1) x = ^e.word;
`endif
                    else                   x = 1'b1;
                    if (c >= line_cap.size() || line_cap[c] !== x) bad++;
                end
                check($sformatf("frame_line_%h", e.word), bad, 0);
            end
            last_line = line_cap;
            line_cap.delete();
        end
        if (popped) begin
            check("pop_legal", {31'd0, (fifo_empty === 1'b0) && tx_en && !reset
                                       && (busy === 1'b0 || frame_done === 1'b1)}, 1);
            sb_q.push_back('{fifo_data, cycle});
            pop_log.push_back(cycle);
            pop_count++;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic wait_pop(input int budget);
        int start;
        int n;
        start = pop_count;
        n = 0;
        while (pop_count == start && n < budget) begin
            cyc();
            n++;
        end
        if (pop_count == start) check("pop_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || fifo_q.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        if (busy !== 1'b0 || fifo_q.size() != 0) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        vecs[0] = '{4'hA, 1'b0, 1};
        vecs[1] = '{4'h7, 1'b1, 2};
        vecs[2] = '{4'h3, 1'b0, 3};
        vecs[3] = '{4'h1, 1'b1, 4};
        vecs[4] = '{4'h8, 1'b1, 5};

        // Reset and idle with an empty FIFO.
        reset = 1'b1;
        tx_en = 1'b0;
        drive_fifo();
        repeat (2) cyc();
        reset = 1'b0;
        #1;
        check("rst_tx_out", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_word_count", word_count, 0);
        check("rst_fifo_pop", fifo_pop, 0);
        tx_en = 1'b1;
        repeat (50) cyc();
        check("empty_no_pop", pop_count, 0);
        check("empty_word_count", word_count, 0);

        // Single words from idle, table driven.
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].word);
            wait_idle(F + 20);
            check($sformatf("tbl_count_%h", vecs[i].word), word_count, vecs[i].exp_cnt);
`ifdef FIFO_TX_PARITY_EN
            check($sformatf("tbl_parity_%h", vecs[i].word),
                  (last_line.size() > (DATA_W+1)*CPB) ? last_line[(DATA_W+1)*CPB] : 1'bx,
                  vecs[i].exp_par);
`endif
            repeat (3) cyc();
        end

        // Back-to-back frames: pops exactly F apart.
        pop_log.delete();
        push(4'h3);
        push(4'hC);
        push(4'h5);
        wait_idle(4 * F);
        check("b2b_pops", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            check("b2b_gap1", pop_log[1] - pop_log[0], F);
            check("b2b_gap2", pop_log[2] - pop_log[1], F);
        end
        check("b2b_count", word_count, 8);
        check("b2b_busy", busy, 0);

        // tx_en dropped mid-frame: frame completes, no further pop.
        push(4'hF);
        push(4'h1);
        pops0 = pop_count;
        wait_pop(10);
        repeat (6) cyc();
        tx_en = 1'b0;
        repeat (F + 10) cyc();
        check("txen_one_pop", pop_count, pops0 + 1);
        check("txen_count", word_count, 9);
        check("txen_busy", busy, 0);
        check("txen_fifo_left", fifo_q.size(), 1);
        tx_en = 1'b1;
        wait_idle(2 * F);
        check("txen_drain_count", word_count, 10);

        // Reset in the middle of a frame.
        push(4'h9);
        wait_pop(10);
        repeat (10) cyc();
        reset = 1'b1;
        #1;
        check("rst_mid_pop", fifo_pop, 0);
        cyc();
        reset = 1'b0;
        #1;
        check("rst_mid_tx_out", tx_out, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_frame_done", frame_done, 0);
        check("rst_mid_count", word_count, 0);
        sb_q.delete();
        line_cap.delete();
        repeat (5) cyc();
        check("rst_mid_no_frame", word_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_nibble_tx.md
# fifo_nibble_tx

Drain-side companion to the team's 4-deep nibble FIFO. It watches the FIFO's empty flag, pops one word at a time, and shifts each word out on a single-wire, UART-style serial line: start bit, data LSB first, optional parity, stop bit. It sits between the FIFO's data_out/fifo_empty outputs and the board-level serial pin, and it is the FIFO's only pop source.

## Interface
- DATA_W, 4, width of one FIFO word / serial payload bits
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 1..255
- CNT_W, 8, width of the completed-frame counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- tx_en  in  1  permission to start new frames; sampled only when a frame may start
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  DATA_W  FIFO head word, valid whenever fifo_empty=0
- fifo_pop  out  1  one-cycle pop strobe to FIFO (combinational, Mealy)
- tx_out  out  1  serial line, idle high
- busy  out  1  high while a frame is in progress (START..STOP)
- frame_done  out  1  one-cycle pulse on the final cycle of each stop bit
- word_count  out  CNT_W  count of completed frames, wraps modulo 2^CNT_W

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP. Each non-IDLE state holds for CLKS_PER_BIT cycles via an 8-bit bit-timer counting 0..CLKS_PER_BIT-1.
- Launch condition L = tx_en & ~fifo_empty & ~reset, evaluated in IDLE or in the last cycle of STOP.
- fifo_pop = L in those cycles, else 0. In the same cycle, fifo_data is latched into the shift register; the next state is START with the bit timer cleared.
- START: tx_out=0. DATA: tx_out=shift[0]; the register shifts right at the end of each bit; the bit index counts 0..DATA_W-1. The last data bit exits to PARITY (if enabled) or STOP.
- STOP: tx_out=1. In the last cycle, frame_done=1 and word_count increments. Next state is START if L (back-to-back, no idle gap), else IDLE.
- IDLE: tx_out=1, busy=0.
- tx_en falling mid-frame has no effect; the frame completes, then the block idles. fifo_empty changes mid-frame are ignored.
- At most one pop per frame; a pop is never issued while fifo_empty=1.

## Timing
- Reset values: tx_out=1, fifo_pop=0, busy=0, frame_done=0, word_count=0, state IDLE.
- Reset mid-frame: the frame is aborted. The next cycle has tx_out=1 and IDLE, with no frame_done and no count increment. fifo_pop=0 during reset.
- Pop-to-start latency: tx_out falls on the cycle after the fifo_pop cycle. busy rises on that same cycle.
- Frame length F = (2 + DATA_W [+1 parity]) * CLKS_PER_BIT cycles; DATA_W=4, CLKS_PER_BIT=4 gives F=24 (28 with parity).
- Back-to-back frames: pop occurs in the last STOP cycle. The next start bit begins immediately after, so the period is exactly F.
- From IDLE with L true, throughput is one frame per F+1 cycles for the first frame. Subsequent back-to-back frames run at one per F.
- CLKS_PER_BIT=1: every state lasts one cycle; the same rules apply.

## Configuration
- FIFO_TX_PARITY_EN defined: a PARITY state is inserted after DATA. tx_out = XOR of all DATA_W latched bits (even parity). F grows by CLKS_PER_BIT.
- FIFO_TX_PARITY_EN undefined: DATA goes directly to STOP; no parity logic is present.

## Test plan
- Reset release, fifo_empty=1, tx_en=1 for 50 cycles -> tx_out=1, fifo_pop never asserted, word_count=0.
- FIFO holds 4'hA, tx_en=1 -> one pop. Line shows 0 for 4 cycles, then 0,1,0,1 (4 cycles each), then 1 for 4 cycles. frame_done fires at cycle 24 after the pop; word_count=1.
- FIFO holds 4'h3, 4'hC, 4'h5 -> pops spaced exactly 24 cycles apart, no idle gap, word_count=3, then IDLE with busy=0.
- tx_en dropped 6 cycles into the frame for 4'hF -> the frame completes normally. No further pop occurs although the FIFO is non-empty.
- reset asserted 10 cycles into a frame -> the next cycle shows tx_out=1, busy=0, no frame_done, and word_count unchanged at its reset value of 0.
- With FIFO_TX_PARITY_EN, send 4'h7 -> parity bit 1, frame 28 cycles. Send 4'h3 -> parity bit 0.
